// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: GPR read-after-write stalls plus a mult/div busy tracker.
// Optional stall statistics counter enabled by defining HAZARD_CTRL_STAT_EN.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1_D,
    input  logic [4:0]  A2_D,
    input  logic [1:0]  Tuse_rs_D,
    input  logic [1:0]  Tuse_rt_D,
    input  logic [4:0]  A3_E,
    input  logic [4:0]  A3_M,
    input  logic [2:0]  Tnew_E,
    input  logic [2:0]  Tnew_M,
    input  logic        RegWrite_E,
    input  logic        RegWrite_M,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    input  logic        md_use_D,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_E,
    output logic        md_busy,
    output logic [3:0]  md_count,
    output logic [31:0] stall_cnt
);

    // state | meaning
    // IDLE  | no mult/div in flight, md_count = 0
    // BUSY  | mult/div occupying the unit, md_count = cycles remaining
    typedef enum logic {IDLE, BUSY} md_state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    md_state_t md_state;
    logic      rs_haz;
    logic      rt_haz;
    logic      md_haz;
    logic      stall;

    // Tuse is zero-extended so Tnew values 4..7 compare at full width
    always_comb begin
        rs_haz = (A1_D != 5'd0) &&
                 ((RegWrite_E && (A1_D == A3_E) && (Tnew_E > {1'b0, Tuse_rs_D})) ||
                  (RegWrite_M && (A1_D == A3_M) && (Tnew_M > {1'b0, Tuse_rs_D})));
        rt_haz = (A2_D != 5'd0) &&
                 ((RegWrite_E && (A2_D == A3_E) && (Tnew_E > {1'b0, Tuse_rt_D})) ||
                  (RegWrite_M && (A2_D == A3_M) && (Tnew_M > {1'b0, Tuse_rt_D})));
        md_haz = md_use_D && (md_busy || md_start_E);
        stall  = !reset && (rs_haz || rt_haz || md_haz);
    end

    assign stall_F = stall;
    assign stall_D = stall;
    assign flush_E = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_state <= IDLE;
            md_count <= 4'd0;
            md_busy  <= 1'b0;
        end else begin
            case (md_state)
                IDLE: begin
                    if (md_start_E) begin
                        md_state <= BUSY;
                        md_count <= md_is_div_E ? DIV_LOAD : MULT_LOAD;
                        md_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    // a new start while busy is dropped; the count is never reloaded
                    md_count <= md_count - 4'd1;
                    if (md_count == 4'd1) begin
                        md_state <= IDLE;
                        md_busy  <= 1'b0;
                    end
                end
                default: begin
                    md_state <= IDLE;
                    md_count <= 4'd0;
                    md_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_CTRL_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed mult/div sequences,
// and randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1_D, A2_D, A3_E, A3_M;
    logic [1:0]  Tuse_rs_D, Tuse_rt_D;
    logic [2:0]  Tnew_E, Tnew_M;
    logic        RegWrite_E, RegWrite_M;
    logic        md_start_E, md_is_div_E, md_use_D;
    logic        stall_F, stall_D, flush_E, md_busy;
    logic [3:0]  md_count;
    logic [31:0] stall_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
        .clk(clk), .reset(reset),
        .A1_D(A1_D), .A2_D(A2_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .A3_E(A3_E), .A3_M(A3_M), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M),
        .md_start_E(md_start_E), .md_is_div_E(md_is_div_E), .md_use_D(md_use_D),
        .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
        .md_busy(md_busy), .md_count(md_count), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [4:0] a1, a2, a3e, a3m;
        logic [1:0] tu_rs, tu_rt;
        logic [2:0] tn_e, tn_m;
        logic       rw_e, rw_m;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_stall(input string name, input logic exp);
        check(name, {29'd0, stall_F, stall_D, flush_E}, exp ? 32'd7 : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        A1_D = 0; A2_D = 0; A3_E = 0; A3_M = 0;
        Tuse_rs_D = 0; Tuse_rt_D = 0; Tnew_E = 0; Tnew_M = 0;
        RegWrite_E = 0; RegWrite_M = 0;
        md_start_E = 0; md_is_div_E = 0; md_use_D = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Reference: hazard per operand from the written rules; unit occupancy as an integer countdown
    function automatic bit gpr_haz(input int src, input int tuse, input bit rwe, input int a3e,
                                   input int tne, input bit rwm, input int a3m, input int tnm);
        if (src == 0) return 0;
        return (rwe && src == a3e && tne > tuse) || (rwm && src == a3m && tnm > tuse);
    endfunction

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_md_count", {28'd0, md_count}, 0);
        check("reset_md_busy", {31'd0, md_busy}, 0);
        check("reset_stall_cnt", stall_cnt, 0);
        // hazard present while reset high must not stall
        A1_D = 1; A3_E = 1; RegWrite_E = 1; Tnew_E = 2; Tuse_rs_D = 1;
        #1;
        check_stall("reset_forces_no_stall", 1'b0);
        clear_inputs();
        reset = 1'b0;
        #1;

        //            a1 a2 a3e a3m rs rt tnE tnM rwE rwM stall
        vecs[0]  = '{5'd1, 5'd0, 5'd1, 5'd0, 2'd1, 2'd0, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1}; // lw->addu
        vecs[1]  = '{5'd1, 5'd0, 5'd0, 5'd1, 2'd1, 2'd0, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0}; // Tnew_M=1
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0}; // $0
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0}; // $0 both
        vecs[4]  = '{5'd0, 5'd9, 5'd9, 5'd0, 2'd0, 2'd2, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1}; // rt via E
        vecs[5]  = '{5'd0, 5'd9, 5'd0, 5'd9, 2'd0, 2'd0, 3'd0, 3'd1, 1'b0, 1'b1, 1'b1}; // rt via M
        vecs[6]  = '{5'd4, 5'd0, 5'd4, 5'd0, 2'd3, 2'd0, 3'd4, 3'd0, 1'b1, 1'b0, 1'b1}; // Tnew 4>3
        vecs[7]  = '{5'd4, 5'd0, 5'd4, 5'd0, 2'd3, 2'd0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0}; // equal
        vecs[8]  = '{5'd4, 5'd0, 5'd4, 5'd0, 2'd0, 2'd0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0}; // no write
        vecs[9]  = '{5'd4, 5'd5, 5'd6, 5'd7, 2'd0, 2'd0, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0}; // no match
        vecs[10] = '{5'd31, 5'd0, 5'd0, 5'd31, 2'd2, 2'd0, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1}; // M 5>2
        vecs[11] = '{5'd3, 5'd3, 5'd3, 5'd0, 2'd2, 2'd0, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1}; // rt only
        for (int i = 0; i < 12; i++) begin
            A1_D = vecs[i].a1; A2_D = vecs[i].a2; A3_E = vecs[i].a3e; A3_M = vecs[i].a3m;
            Tuse_rs_D = vecs[i].tu_rs; Tuse_rt_D = vecs[i].tu_rt;
            Tnew_E = vecs[i].tn_e; Tnew_M = vecs[i].tn_m;
            RegWrite_E = vecs[i].rw_e; RegWrite_M = vecs[i].rw_m;
            #1;
            check_stall($sformatf("vec%0d_stall", i), vecs[i].exp_stall);
        end
        clear_inputs();

        // stall statistics: 7 stall cycles after a reset
        do_reset();
        A1_D = 1; A3_E = 1; RegWrite_E = 1; Tnew_E = 2; Tuse_rs_D = 1;
        repeat (7) tick();
        clear_inputs();
        #1;
`ifdef HAZARD_CTRL_STAT_EN
        check("stall_cnt_7", stall_cnt, 7);
`else
        check("stall_cnt_7", stall_cnt, 0);
`endif

        // mult with mfhi waiting: start cycle plus MULT_C busy cycles
        do_reset();
        md_use_D = 1; md_start_E = 1; md_is_div_E = 0;
        #1;
        check_stall("mult_start_stall", 1'b1);
        tick();
        md_start_E = 0;
        for (int k = MULT_C; k >= 1; k--) begin
            #1;
            check($sformatf("mult_count_%0d", k), {28'd0, md_count}, k);
            check_stall($sformatf("mult_stall_%0d", k), 1'b1);
            tick();
        end
        #1;
        check("mult_done_count", {28'd0, md_count}, 0);
        check("mult_done_busy", {31'd0, md_busy}, 0);
        check_stall("mult_done_stall", 1'b0);

        // div aborted by reset at count 6
        clear_inputs();
        do_reset();
        md_start_E = 1; md_is_div_E = 1;
        tick();
        md_start_E = 0; md_is_div_E = 0; md_use_D = 1;
        check("div_load", {28'd0, md_count}, DIV_C);
        repeat (DIV_C - 6) tick();
        check("div_at_6", {28'd0, md_count}, 6);
        reset = 1'b1;
        #1;
        check_stall("div_reset_stall", 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check("div_abort_count", {28'd0, md_count}, 0);
        check("div_abort_busy", {31'd0, md_busy}, 0);
        check_stall("div_abort_stall", 1'b0);

        // restart while busy is ignored
        clear_inputs();
        md_start_E = 1;
        tick();
        md_start_E = 0;
        repeat (MULT_C - 3) tick();
        check("restart_at_3", {28'd0, md_count}, 3);
        md_start_E = 1; md_is_div_E = 1;
        tick();
        md_start_E = 0; md_is_div_E = 0;
        check("restart_2", {28'd0, md_count}, 2);
        tick();
        check("restart_1", {28'd0, md_count}, 1);
        tick();
        check("restart_0", {28'd0, md_count}, 0);
        check("restart_busy", {31'd0, md_busy}, 0);

        // randomized traffic against the reference model
        begin
            int  rem;
            int  cnt;
            bit  exp_st;
            clear_inputs();
            do_reset();
            rem = 0;
            cnt = 0;
            for (int c = 0; c < 400; c++) begin
                reset       = ($urandom_range(0, 29) == 0);
                A1_D        = 5'($urandom_range(0, 3));
                A2_D        = 5'($urandom_range(0, 3));
                A3_E        = 5'($urandom_range(0, 3));
                A3_M        = 5'($urandom_range(0, 3));
                Tuse_rs_D   = 2'($urandom_range(0, 3));
                Tuse_rt_D   = 2'($urandom_range(0, 3));
                Tnew_E      = 3'($urandom_range(0, 7));
                Tnew_M      = 3'($urandom_range(0, 7));
                RegWrite_E  = 1'($urandom_range(0, 1));
                RegWrite_M  = 1'($urandom_range(0, 1));
                md_start_E  = ($urandom_range(0, 5) == 0);
                md_is_div_E = 1'($urandom_range(0, 1));
                md_use_D    = 1'($urandom_range(0, 1));
                #1;
                exp_st = !reset && (
                    gpr_haz(A1_D, Tuse_rs_D, RegWrite_E, A3_E, Tnew_E, RegWrite_M, A3_M, Tnew_M) ||
                    gpr_haz(A2_D, Tuse_rt_D, RegWrite_E, A3_E, Tnew_E, RegWrite_M, A3_M, Tnew_M) ||
                    (md_use_D && (rem > 0 || md_start_E)));
                check("rnd_stall", {29'd0, stall_F, stall_D, flush_E}, exp_st ? 32'd7 : 32'd0);
                check("rnd_count", {28'd0, md_count}, rem);
                check("rnd_busy", {31'd0, md_busy}, (rem > 0) ? 1 : 0);
`ifdef HAZARD_CTRL_STAT_EN
                check("rnd_stall_cnt", stall_cnt, cnt);
`else
                check("rnd_stall_cnt", stall_cnt, 0);
`endif
                tick();
                if (reset) begin
                    rem = 0;
                    cnt = 0;
                end else begin
                    if (exp_st) cnt++;
                    if (rem > 0) rem--;
                    else if (md_start_E) rem = md_is_div_E ? DIV_C : MULT_C;
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
